// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and writeback.
// Waits for the data_ok response of any load/store issued in execute,
// extracts and extends load data, and forwards results, exceptions and
// bypass info. Responses orphaned by a writeback flush are counted and
// discarded when they eventually arrive.
// Optional build macro MS_STALL_CNT_EN adds the ms_stall_cnt output, a
// free-running count of cycles spent waiting for data.
module mem_stage #(
  parameter int unsigned EXC_W    = 8,
  parameter int unsigned CANCEL_W = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              es2ms_valid,
  output logic              ms_allowin,
  input  logic              es_mem_req,
  input  logic [4:0]        es_ld_op,
  input  logic [31:0]       es_pc,
  input  logic              es_rf_we,
  input  logic [4:0]        es_rf_waddr,
  input  logic [31:0]       es_result,
  input  logic [EXC_W-1:0]  es_exc,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata,
  input  logic              ws_allowin,
  input  logic              wb_ex,
  output logic              ms2ws_valid,
  output logic [31:0]       ms_pc,
  output logic              ms_rf_we,
  output logic [4:0]        ms_rf_waddr,
  output logic [31:0]       ms_rf_wdata,
  output logic [EXC_W-1:0]  ms_exc,
  output logic              ms_ex,
  output logic [31:0]       ms_badv,
`ifdef MS_STALL_CNT_EN
  output logic [31:0]       ms_stall_cnt,
`endif
  output logic              ms_ld_wait
);

  localparam int unsigned       DATA_W  = 32;
  localparam logic [CANCEL_W-1:0] CNT_MAX = '1;

  // ld_op bit positions: {ld_b, ld_bu, ld_h, ld_hu, ld_w}
  localparam int unsigned LD_B  = 4;
  localparam int unsigned LD_BU = 3;
  localparam int unsigned LD_H  = 2;
  localparam int unsigned LD_HU = 1;
  localparam int unsigned LD_W  = 0;

  logic                ms_valid_q, ms_valid_d;
  logic                mem_req_q;
  logic [4:0]          ld_op_q;
  logic [31:0]         pc_q;
  logic                rf_we_q;
  logic [4:0]          rf_waddr_q;
  logic [DATA_W-1:0]   result_q;
  logic [EXC_W-1:0]    exc_q;
  logic                got_data_q, got_data_d;
  logic [DATA_W-1:0]   rdata_buf_q, rdata_buf_d;
  logic [CANCEL_W-1:0] discard_cnt_q, discard_cnt_d;

  logic              has_exc;
  logic              wait_data;
  logic              data_ok_eff;
  logic              ready_go;
  logic              allowin_int;
  logic              capture;
  logic              cnt_inc;
  logic              cnt_dec;
  logic [DATA_W-1:0] ld_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  // Handshake and wait qualification
  always_comb begin
    has_exc     = |exc_q;
    data_ok_eff = data_sram_data_ok & (discard_cnt_q == '0);
    wait_data   = ms_valid_q & mem_req_q & ~has_exc & ~got_data_q;
    ready_go    = ~wait_data | data_ok_eff;
    allowin_int = ~ms_valid_q | (ready_go & ws_allowin);
    capture     = es2ms_valid & allowin_int & ~wb_ex;
    cnt_inc     = wb_ex & wait_data & ~data_ok_eff;
    cnt_dec     = data_sram_data_ok & (discard_cnt_q != '0);
  end

  // Next-state for valid, response buffer and discard counter
  always_comb begin
    ms_valid_d    = ms_valid_q;
    got_data_d    = got_data_q;
    rdata_buf_d   = rdata_buf_q;
    discard_cnt_d = discard_cnt_q;

    if (wb_ex) begin
      ms_valid_d = 1'b0;
    end else if (allowin_int) begin
      ms_valid_d = es2ms_valid;
    end

    if (wb_ex || allowin_int) begin
      got_data_d = 1'b0;
    end else if (wait_data && data_ok_eff && !ws_allowin) begin
      got_data_d  = 1'b1;
      rdata_buf_d = data_sram_rdata;
    end

    if (cnt_inc && !cnt_dec) begin
      if (discard_cnt_q != CNT_MAX) begin
        discard_cnt_d = discard_cnt_q + CANCEL_W'(1);
      end
    end else if (cnt_dec && !cnt_inc) begin
      discard_cnt_d = discard_cnt_q - CANCEL_W'(1);
    end
  end

  // Stage state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q    <= 1'b0;
      got_data_q    <= 1'b0;
      rdata_buf_q   <= '0;
      discard_cnt_q <= '0;
    end else begin
      ms_valid_q    <= ms_valid_d;
      got_data_q    <= got_data_d;
      rdata_buf_q   <= rdata_buf_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  // Instruction payload latched on capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_req_q  <= 1'b0;
      ld_op_q    <= '0;
      pc_q       <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      result_q   <= '0;
      exc_q      <= '0;
    end else if (capture) begin
      mem_req_q  <= es_mem_req;
      ld_op_q    <= es_ld_op;
      pc_q       <= es_pc;
      rf_we_q    <= es_rf_we;
      rf_waddr_q <= es_rf_waddr;
      result_q   <= es_result;
      exc_q      <= es_exc;
    end
  end

  // Load data selection and extension
  always_comb begin
    ld_word = got_data_q ? rdata_buf_q : data_sram_rdata;
    ld_half = result_q[1] ? ld_word[31:16] : ld_word[15:0];
    unique case (result_q[1:0])
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase

    ms_rf_wdata = result_q;
    if (ld_op_q[LD_W]) begin
      ms_rf_wdata = ld_word;
    end else if (ld_op_q[LD_B]) begin
      ms_rf_wdata = {{24{ld_byte[7]}}, ld_byte};
    end else if (ld_op_q[LD_BU]) begin
      ms_rf_wdata = {24'd0, ld_byte};
    end else if (ld_op_q[LD_H]) begin
      ms_rf_wdata = {{16{ld_half[15]}}, ld_half};
    end else if (ld_op_q[LD_HU]) begin
      ms_rf_wdata = {16'd0, ld_half};
    end
  end

  // Stage outputs; allowin is forced low while reset is asserted
  always_comb begin
    ms_allowin  = resetn & allowin_int;
    ms2ws_valid = ms_valid_q & ready_go;
    ms_pc       = pc_q;
    ms_rf_we    = ms_valid_q & rf_we_q & ~has_exc;
    ms_rf_waddr = rf_waddr_q;
    ms_exc      = exc_q;
    ms_ex       = ms_valid_q & has_exc;
    ms_badv     = result_q;
    ms_ld_wait  = ms_valid_q & (|ld_op_q) & ~ready_go;
  end

`ifdef MS_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Free-running count of cycles stalled on an outstanding response
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
    end else if (wait_data && !data_ok_eff) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign ms_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;

  localparam int unsigned EXC_W = 8;

  logic              clk;
  logic              resetn;
  logic              es2ms_valid;
  logic              ms_allowin;
  logic              es_mem_req;
  logic [4:0]        es_ld_op;
  logic [31:0]       es_pc;
  logic              es_rf_we;
  logic [4:0]        es_rf_waddr;
  logic [31:0]       es_result;
  logic [EXC_W-1:0]  es_exc;
  logic              data_sram_data_ok;
  logic [31:0]       data_sram_rdata;
  logic              ws_allowin;
  logic              wb_ex;
  logic              ms2ws_valid;
  logic [31:0]       ms_pc;
  logic              ms_rf_we;
  logic [4:0]        ms_rf_waddr;
  logic [31:0]       ms_rf_wdata;
  logic [EXC_W-1:0]  ms_exc;
  logic              ms_ex;
  logic [31:0]       ms_badv;
  logic              ms_ld_wait;
`ifdef MS_STALL_CNT_EN
  logic [31:0]       ms_stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [4:0] OP_W  = 5'b00001;
  localparam logic [4:0] OP_HU = 5'b00010;
  localparam logic [4:0] OP_H  = 5'b00100;
  localparam logic [4:0] OP_BU = 5'b01000;
  localparam logic [4:0] OP_B  = 5'b10000;

  mem_stage #(.EXC_W(EXC_W), .CANCEL_W(2)) dut (
    .clk(clk), .resetn(resetn),
    .es2ms_valid(es2ms_valid), .ms_allowin(ms_allowin),
    .es_mem_req(es_mem_req), .es_ld_op(es_ld_op), .es_pc(es_pc),
    .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr), .es_result(es_result),
    .es_exc(es_exc), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .ws_allowin(ws_allowin), .wb_ex(wb_ex),
    .ms2ws_valid(ms2ws_valid), .ms_pc(ms_pc), .ms_rf_we(ms_rf_we),
    .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata), .ms_exc(ms_exc),
    .ms_ex(ms_ex), .ms_badv(ms_badv),
`ifdef MS_STALL_CNT_EN
    .ms_stall_cnt(ms_stall_cnt),
`endif
    .ms_ld_wait(ms_ld_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    es2ms_valid = 0; es_mem_req = 0; es_ld_op = '0; es_pc = '0;
    es_rf_we = 0; es_rf_waddr = '0; es_result = '0; es_exc = '0;
    data_sram_data_ok = 0; data_sram_rdata = '0; ws_allowin = 1; wb_ex = 0;
  endtask

  task automatic issue(input logic mreq, input logic [4:0] op, input logic [31:0] pc,
                       input logic [31:0] res, input logic we, input logic [EXC_W-1:0] exc);
    es2ms_valid = 1; es_mem_req = mreq; es_ld_op = op; es_pc = pc;
    es_rf_we = we; es_rf_waddr = 5'd7; es_result = res; es_exc = exc;
  endtask

  task automatic test_reset();
    resetn = 0;
    idle_inputs();
    #3;
    n_cmp++; if (ms_allowin !== 1'b0) begin n_err++; $display("FAIL reset_allowin got %b exp 0", ms_allowin); end
    n_cmp++; if (ms2ws_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", ms2ws_valid); end
    n_cmp++; if ({ms_pc, ms_rf_wdata, ms_badv} !== 96'd0) begin n_err++; $display("FAIL reset_data got %h %h %h exp 0", ms_pc, ms_rf_wdata, ms_badv); end
    n_cmp++; if ({ms_rf_we, ms_ex, ms_ld_wait, ms_exc, ms_rf_waddr} !== 16'd0) begin n_err++; $display("FAIL reset_ctrl got %b%b%b %h %h exp 0", ms_rf_we, ms_ex, ms_ld_wait, ms_exc, ms_rf_waddr); end
    @(negedge clk);
    resetn = 1;
    cyc();
    n_cmp++; if (ms_allowin !== 1'b1) begin n_err++; $display("FAIL post_reset_allowin got %b exp 1", ms_allowin); end
  endtask

  task automatic test_ld_w();
    issue(1, OP_W, 32'h100, 32'h1000, 1, '0);
    cyc();
    es2ms_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (ms_ld_wait !== 1'b1 || ms2ws_valid !== 1'b0) begin n_err++; $display("FAIL ldw_wait%0d got wait=%b v=%b exp 1/0", i, ms_ld_wait, ms2ws_valid); end
      cyc();
    end
    data_sram_data_ok = 1; data_sram_rdata = 32'hDEADBEEF;
    #1;
    n_cmp++; if (ms2ws_valid !== 1'b1) begin n_err++; $display("FAIL ldw_valid got %b exp 1", ms2ws_valid); end
    n_cmp++; if (ms_rf_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL ldw_wdata got %h exp deadbeef", ms_rf_wdata); end
    n_cmp++; if (ms_ld_wait !== 1'b0) begin n_err++; $display("FAIL ldw_wait_done got %b exp 0", ms_ld_wait); end
    n_cmp++; if (ms_rf_we !== 1'b1 || ms_pc !== 32'h100 || ms_rf_waddr !== 5'd7) begin n_err++; $display("FAIL ldw_fields got we=%b pc=%h wa=%0d exp 1/100/7", ms_rf_we, ms_pc, ms_rf_waddr); end
    cyc();
    data_sram_data_ok = 0;
    #1;
    n_cmp++; if (ms2ws_valid !== 1'b0) begin n_err++; $display("FAIL ldw_leave got %b exp 0", ms2ws_valid); end
  endtask

  task automatic test_extend();
    logic [4:0]  ops [4]  = '{OP_B, OP_BU, OP_H, OP_HU};
    logic [31:0] addr [4] = '{32'h2003, 32'h2003, 32'h2002, 32'h2002};
    logic [31:0] exp [4]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    for (int i = 0; i < 4; i++) begin
      issue(1, ops[i], 32'h200, addr[i], 1, '0);
      cyc();
      es2ms_valid = 0;
      data_sram_data_ok = 1; data_sram_rdata = 32'h80FF0000;
      #1;
      n_cmp++; if (ms_rf_wdata !== exp[i] || ms2ws_valid !== 1'b1) begin n_err++; $display("FAIL extend%0d got %h v=%b exp %h", i, ms_rf_wdata, ms2ws_valid, exp[i]); end
      cyc();
      data_sram_data_ok = 0;
    end
  endtask

  task automatic test_buffer();
    issue(1, OP_W, 32'h300, 32'h2000, 1, '0);
    ws_allowin = 0;
    cyc();
    es2ms_valid = 0;
    data_sram_data_ok = 1; data_sram_rdata = 32'h12345678;
    cyc();
    data_sram_data_ok = 0; data_sram_rdata = 32'hFFFFFFFF;
    #1;
    n_cmp++; if (ms2ws_valid !== 1'b1 || ms_allowin !== 1'b0) begin n_err++; $display("FAIL buf_hold got v=%b a=%b exp 1/0", ms2ws_valid, ms_allowin); end
    n_cmp++; if (ms_rf_wdata !== 32'h12345678) begin n_err++; $display("FAIL buf_data1 got %h exp 12345678", ms_rf_wdata); end
    cyc();
    data_sram_rdata = 32'h0BADF00D;
    ws_allowin = 1;
    #1;
    n_cmp++; if (ms_rf_wdata !== 32'h12345678 || ms_allowin !== 1'b1) begin n_err++; $display("FAIL buf_data2 got %h a=%b exp 12345678/1", ms_rf_wdata, ms_allowin); end
    cyc();
    n_cmp++; if (ms2ws_valid !== 1'b0) begin n_err++; $display("FAIL buf_leave got %b exp 0", ms2ws_valid); end
  endtask

  task automatic test_flush();
    issue(1, OP_W, 32'h400, 32'h3000, 1, '0);
    cyc();
    es2ms_valid = 0;
    wb_ex = 1;
    cyc();
    wb_ex = 0;
    issue(1, OP_W, 32'h404, 32'h3004, 1, '0);
    #1;
    n_cmp++; if (dut.discard_cnt_q !== 2'd1 || ms2ws_valid !== 1'b0) begin n_err++; $display("FAIL flush_cnt got %0d v=%b exp 1/0", dut.discard_cnt_q, ms2ws_valid); end
    cyc();
    es2ms_valid = 0;
    data_sram_data_ok = 1; data_sram_rdata = 32'hAAAAAAAA;
    #1;
    n_cmp++; if (ms2ws_valid !== 1'b0 || ms_ld_wait !== 1'b1) begin n_err++; $display("FAIL flush_discard got v=%b w=%b exp 0/1", ms2ws_valid, ms_ld_wait); end
    cyc();
    data_sram_rdata = 32'h55555555;
    #1;
    n_cmp++; if (ms2ws_valid !== 1'b1 || ms_rf_wdata !== 32'h55555555) begin n_err++; $display("FAIL flush_second got v=%b %h exp 1/55555555", ms2ws_valid, ms_rf_wdata); end
    n_cmp++; if (dut.discard_cnt_q !== 2'd0) begin n_err++; $display("FAIL flush_cnt0 got %0d exp 0", dut.discard_cnt_q); end
    cyc();
    data_sram_data_ok = 0;
  endtask

  task automatic test_store_exc();
    issue(1, 5'd0, 32'h500, 32'hBAD00003, 0, 8'h04);
    cyc();
    es2ms_valid = 0;
    #1;
    n_cmp++; if (ms2ws_valid !== 1'b1 || ms_ex !== 1'b1) begin n_err++; $display("FAIL st_exc got v=%b ex=%b exp 1/1", ms2ws_valid, ms_ex); end
    n_cmp++; if (ms_rf_we !== 1'b0 || ms_badv !== 32'hBAD00003 || ms_exc !== 8'h04) begin n_err++; $display("FAIL st_fields got we=%b badv=%h exc=%h exp 0/bad00003/04", ms_rf_we, ms_badv, ms_exc); end
    cyc();
    issue(0, 5'd0, 32'h504, 32'h00001234, 1, '0);
    cyc();
    es2ms_valid = 0;
    #1;
    n_cmp++; if (ms2ws_valid !== 1'b1 || ms_rf_wdata !== 32'h1234 || ms_rf_we !== 1'b1 || ms_ex !== 1'b0) begin n_err++; $display("FAIL alu_pass got v=%b %h we=%b ex=%b exp 1/1234/1/0", ms2ws_valid, ms_rf_wdata, ms_rf_we, ms_ex); end
    cyc();
  endtask

  task automatic test_back_to_back();
    issue(1, OP_W, 32'h600, 32'h4000, 1, '0);
    cyc();
    issue(1, OP_BU, 32'h604, 32'h4001, 1, '0);
    data_sram_data_ok = 1; data_sram_rdata = 32'hCAFE1234;
    #1;
    n_cmp++; if (ms_pc !== 32'h600 || ms_rf_wdata !== 32'hCAFE1234 || ms2ws_valid !== 1'b1) begin n_err++; $display("FAIL b2b_first got pc=%h %h v=%b exp 600/cafe1234/1", ms_pc, ms_rf_wdata, ms2ws_valid); end
    cyc();
    es2ms_valid = 0;
    data_sram_data_ok = 0;
    #1;
    n_cmp++; if (ms_pc !== 32'h604 || ms2ws_valid !== 1'b0 || ms_ld_wait !== 1'b1) begin n_err++; $display("FAIL b2b_wait got pc=%h v=%b w=%b exp 604/0/1", ms_pc, ms2ws_valid, ms_ld_wait); end
    cyc();
    data_sram_data_ok = 1; data_sram_rdata = 32'h0000AB00;
    #1;
    n_cmp++; if (ms_rf_wdata !== 32'h000000AB || ms2ws_valid !== 1'b1) begin n_err++; $display("FAIL b2b_second got %h v=%b exp 000000ab/1", ms_rf_wdata, ms2ws_valid); end
    cyc();
    data_sram_data_ok = 0;
  endtask

  task automatic test_reset_midwait();
    issue(1, OP_W, 32'h700, 32'h5000, 1, '0);
    cyc();
    es2ms_valid = 0;
    #1;
    n_cmp++; if (ms_ld_wait !== 1'b1) begin n_err++; $display("FAIL rst_pre_wait got %b exp 1", ms_ld_wait); end
    #1;
    resetn = 0;
    #1;
    n_cmp++; if (ms_allowin !== 1'b0 || ms2ws_valid !== 1'b0 || ms_ld_wait !== 1'b0) begin n_err++; $display("FAIL rst_mid_ctrl got a=%b v=%b w=%b exp 0", ms_allowin, ms2ws_valid, ms_ld_wait); end
    n_cmp++; if (ms_pc !== 32'd0 || ms_badv !== 32'd0 || ms_rf_we !== 1'b0) begin n_err++; $display("FAIL rst_mid_data got pc=%h badv=%h we=%b exp 0", ms_pc, ms_badv, ms_rf_we); end
    @(negedge clk);
    resetn = 1;
    cyc();
    n_cmp++; if (ms_allowin !== 1'b1 || ms2ws_valid !== 1'b0) begin n_err++; $display("FAIL rst_release got a=%b v=%b exp 1/0", ms_allowin, ms2ws_valid); end
    cyc();
    n_cmp++; if (ms2ws_valid !== 1'b0) begin n_err++; $display("FAIL rst_spurious got %b exp 0", ms2ws_valid); end
  endtask

  initial begin
    test_reset();
    test_ld_w();
    test_extend();
    test_buffer();
    test_flush();
    test_store_exc();
    test_back_to_back();
    test_reset_midwait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage, upstream of writeback.
- Accepts instructions from execute and waits for the SRAM-like data_ok response of any load/store issued there.
- For loads, extracts and extends the returned data. Forwards results, exception state and bypass info to writeback and decode.
- Tracks responses orphaned by a writeback flush so that stale data_ok beats are discarded.

Parameters:
EXC_W, 8, width of the exception vector carried with each instruction
CANCEL_W, 2, width of the orphaned-response discard counter

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
es2ms_valid  in  1  execute stage holds a valid instruction
ms_allowin  out  1  this stage can accept an instruction
es_mem_req  in  1  instruction issued a data request in execute
es_ld_op  in  5  {ld_b, ld_bu, ld_h, ld_hu, ld_w}
es_pc  in  32  instruction PC
es_rf_we  in  1  register write enable
es_rf_waddr  in  5  destination register
es_result  in  32  ALU result / virtual address
es_exc  in  EXC_W  exception bits accumulated upstream
data_sram_data_ok  in  1  data response strobe
data_sram_rdata  in  32  data response word
ws_allowin  in  1  writeback can accept
wb_ex  in  1  flush from writeback (exception/ertn/refetch)
ms2ws_valid  out  1  valid instruction to writeback
ms_pc  out  32  PC to writeback
ms_rf_we  out  1  write enable (valid-qualified)
ms_rf_waddr  out  5  destination register
ms_rf_wdata  out  32  load data or passed-through result
ms_exc  out  EXC_W  exception bits to writeback
ms_ex  out  1  |ms_exc & ms_valid; used by execute to suppress requests
ms_badv  out  32  es_result latched, bad virtual address
ms_ld_wait  out  1  valid load whose data is not yet available, for decode interlock

Behaviour:
- Clock and reset: single clock clk; reset resetn is asynchronous, active-low.
- Reset values:
  - all outputs 0, including ms_allowin=0 during reset.
  - ms_valid=0, got_data=0, rdata_buf=0, discard_cnt=0.
- Capture: when es2ms_valid & ms_allowin, latch all es_* fields; ms_valid<=1. ms_valid<=0 when ms_allowin and no es2ms_valid.
- wb_ex clears ms_valid the next edge; it has priority over capture.
- wait_data = ms_valid & mem_req_l & ~(|exc_l) & ~got_data.
- ms_ready_go = ~wait_data | data_ok_eff.
- data_ok_eff = data_sram_data_ok & (discard_cnt==0).
- ms_allowin = ~ms_valid | ms_ready_go & ws_allowin.
- ms2ws_valid = ms_valid & ms_ready_go.
- Response buffering:
  - If data_ok_eff arrives while ws_allowin=0, store rdata in rdata_buf and set got_data.
  - got_data clears when the instruction leaves or on wb_ex.
  - The load word used is got_data ? rdata_buf : data_sram_rdata.
- Flush accounting:
  - If wb_ex occurs while wait_data & ~data_ok_eff, discard_cnt increments, saturating at 2^CANCEL_W-1.
  - Each data_sram_data_ok seen with discard_cnt!=0 decrements discard_cnt and is otherwise ignored.
- Load extraction (offset = result_l[1:0]):
  - ld_w: word.
  - ld_b/bu: byte[offset], sign-/zero-extended.
  - ld_h/hu: halfword[offset[1]], sign-/zero-extended.
  - Non-loads: ms_rf_wdata = result_l.
- Misaligned offsets never reach here without an exception bit; with an exception, ms_rf_we=0.
- ms_rf_we = ms_valid & rf_we_l & ~(|exc_l).
- ms_ld_wait = ms_valid & (|ld_op_l) & ~ms_ready_go.
- Simultaneous events:
  - data_ok_eff and wb_ex in the same cycle: the response is consumed and not counted.
  - Capture and data_ok of the previous instruction in the same cycle: the response belongs to the previous instruction, which is leaving.

Optional Feature:
MS_STALL_CNT_EN: adds output ms_stall_cnt [31:0], a free-running counter of cycles with wait_data & ~data_ok_eff. It resets to 0 asynchronously and wraps at 2^32. Without the macro the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- ld_w, result=0x1000, data_ok 3 cycles later with rdata 0xDEADBEEF, ws_allowin=1 -> ms2ws_valid on data_ok cycle; ms_rf_wdata=0xDEADBEEF; ms_ld_wait=1 for 3 cycles.
- ld_b offset 3, rdata 0x80FF_0000 -> wdata 0xFFFFFF80. Same with ld_bu -> 0x00000080. ld_h offset 2 -> 0xFFFF80FF.
- data_ok with ws_allowin=0 for 2 cycles, rdata 0x12345678, bus changes afterward -> wdata remains 0x12345678 when ws_allowin rises.
- Load waiting, wb_ex pulse, new load captured, then two data_ok beats (0xAAAA_AAAA, 0x5555_5555) -> first discarded; second load writes 0x55555555; discard_cnt returns to 0.
- Store with es_exc!=0 -> passes in 1 cycle without waiting; ms_ex=1; ms_rf_we=0; ms_badv=result.
- resetn deasserted mid-wait -> all outputs 0 immediately; after release, ms_allowin=1 and no spurious ms2ws_valid.
